fetch_unit: RTL and testbench

Instruction-fetch front end sitting directly upstream of the mmu instruction port.
- Holds the bundle PC and issues one translated-fetch request at a time (doFetch pulse + virtual address).
- Captures each returned NFU*32-bit bundle into a small FIFO that feeds decode/dispatch through a valid/ready handshake.
- Supports redirects from branch resolution with squash of the in-flight request.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_buffer.sv | 69 ++++++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state/entry types and sizing helpers for the fetch front end
package fetch_pkg;
   localparam int NFU_DEFAULT = 2;
   localparam int VA_DEFAULT  = 64;
   localparam int BUNDLE_BITS = NFU_DEFAULT * 32;
   localparam int STRIDE      = NFU_DEFAULT * 4;
   localparam int ALIGN_BITS  = $clog2(STRIDE);

   typedef enum logic [0:0] {ISSUE, WAIT} fetch_state_t;

   typedef struct packed {
      logic [BUNDLE_BITS-1:0] bundle;
      logic [VA_DEFAULT-1:0]  pc;
   } bundle_entry_t;

   function automatic int bundle_bits(input int nfu);
      return nfu * 32;
   endfunction

   function automatic int stride_bytes(input int nfu);
      return nfu * 4;
   endfunction

   function automatic int align_bits(input int nfu);
      return $clog2(nfu * 4);
   endfunction
endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - bundle FIFO with flush; head is read directly from registered storage
module fetch_buffer #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full      = (count_q == (PW+1)'(DEPTH));
   assign empty     = (count_q == '0);
   assign head_data = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Flush wins over any same-cycle push/pop; storage contents are left stale.
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch front end: holds the bundle PC, issues one mmu request at a time,
// queues returned bundles for decode and squashes the in-flight request on redirect.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                              VIRTUAL_ADDRESS_SIZE = VA_DEFAULT,
   parameter int                              NFU                  = NFU_DEFAULT,
   parameter int                              BUF_DEPTH            = 4,
   parameter logic [VIRTUAL_ADDRESS_SIZE-1:0] RESET_PC             = '0
) (
   input  logic                            clk,
   input  logic                            reset,
   output logic [VIRTUAL_ADDRESS_SIZE-1:0] fetchAddress,
   output logic                            doFetch,
   input  logic [NFU*32-1:0]               fetchData,
   input  logic                            doneFetch,
   input  logic                            redirectValid,
   input  logic [VIRTUAL_ADDRESS_SIZE-1:0] redirectTarget,
   output logic                            bundleValid,
   output logic [NFU*32-1:0]               bundleOut,
   output logic [VIRTUAL_ADDRESS_SIZE-1:0] bundlePc,
   input  logic                            bundleReady
);
   localparam int BUNDLE_W = bundle_bits(NFU);
   localparam int ALIGN_W  = align_bits(NFU);
   localparam int ENTRY_W  = BUNDLE_W + VIRTUAL_ADDRESS_SIZE;
   localparam logic [VIRTUAL_ADDRESS_SIZE-1:0] STRIDE_V = VIRTUAL_ADDRESS_SIZE'(stride_bytes(NFU));

   fetch_state_t                    state_q, state_d;
   logic [VIRTUAL_ADDRESS_SIZE-1:0] pc_q, pc_d;
   logic [VIRTUAL_ADDRESS_SIZE-1:0] fetch_addr_q, fetch_addr_d;
   logic                            squash_q, squash_d;
   logic                            do_fetch_q, do_fetch_d;
   logic                            buf_push, buf_pop, buf_flush;
   logic                            buf_full, buf_empty;
   logic [ENTRY_W-1:0]              buf_head;

   fetch_buffer #(
      .WIDTH (ENTRY_W),
      .DEPTH (BUF_DEPTH)
   ) u_buffer (
      .clk       (clk),
      .reset     (reset),
      .flush     (buf_flush),
      .push      (buf_push),
      .push_data ({fetchData, fetch_addr_q}),
      .pop       (buf_pop),
      .head_data (buf_head),
      .full      (buf_full),
      .empty     (buf_empty)
   );

   assign fetchAddress           = fetch_addr_q;
   assign doFetch                = do_fetch_q;
   assign bundleValid            = !buf_empty;
   assign {bundleOut, bundlePc}  = buf_empty ? '0 : buf_head;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fetch_addr_d = fetch_addr_q;
      squash_d     = squash_q;
      do_fetch_d   = 1'b0;
      buf_push     = 1'b0;
      buf_flush    = 1'b0;
      buf_pop      = !buf_empty && bundleReady;
      if (redirectValid) begin
         // The flush also voids any same-cycle dequeue inside the buffer.
         pc_d      = {redirectTarget[VIRTUAL_ADDRESS_SIZE-1:ALIGN_W], ALIGN_W'(0)};
         buf_flush = 1'b1;
         if (state_q == WAIT) begin
            if (doneFetch) begin
               squash_d = 1'b0;
               state_d  = ISSUE;
            end else begin
               squash_d = 1'b1;
            end
         end
      end else begin
         case (state_q)
            ISSUE: begin
               if (!buf_full) begin
                  do_fetch_d   = 1'b1;
                  fetch_addr_d = pc_q;
                  state_d      = WAIT;
               end
            end
            WAIT: begin
               if (doneFetch) begin
                  if (squash_q) begin
                     squash_d = 1'b0;
                  end else begin
                     buf_push = 1'b1;
                     pc_d     = pc_q + STRIDE_V;
                  end
                  state_d = ISSUE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ISSUE;
         pc_q         <= RESET_PC;
         fetch_addr_q <= RESET_PC;
         squash_q     <= 1'b0;
         do_fetch_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fetch_addr_q <= fetch_addr_d;
         squash_q     <= squash_d;
         do_fetch_q   <= do_fetch_d;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against a transaction-level reference model
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int          DEPTH = 4;
   localparam logic [63:0] RPC   = 64'h1000;
   localparam logic [63:0] STEP  = 64'(STRIDE);
   localparam logic [63:0] AMASK = ~((64'd1 << ALIGN_BITS) - 64'd1);

   logic                   clk = 1'b0;
   logic                   reset;
   logic [VA_DEFAULT-1:0]  fetchAddress;
   logic                   doFetch;
   logic [BUNDLE_BITS-1:0] fetchData;
   logic                   doneFetch;
   logic                   redirectValid;
   logic [VA_DEFAULT-1:0]  redirectTarget;
   logic                   bundleValid;
   logic [BUNDLE_BITS-1:0] bundleOut;
   logic [VA_DEFAULT-1:0]  bundlePc;
   logic                   bundleReady;

   always #5 clk = ~clk;

   fetch_unit #(
      .VIRTUAL_ADDRESS_SIZE (VA_DEFAULT),
      .NFU                  (NFU_DEFAULT),
      .BUF_DEPTH            (DEPTH),
      .RESET_PC             (RPC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .fetchAddress   (fetchAddress),
      .doFetch        (doFetch),
      .fetchData      (fetchData),
      .doneFetch      (doneFetch),
      .redirectValid  (redirectValid),
      .redirectTarget (redirectTarget),
      .bundleValid    (bundleValid),
      .bundleOut      (bundleOut),
      .bundlePc       (bundlePc),
      .bundleReady    (bundleReady)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: an outstanding-request flag, a squash flag, the next PC and a queue of bundles.
   bundle_entry_t mq[$];
   logic [63:0]   m_pc       = RPC;
   logic [63:0]   m_inflight = '0;
   logic [63:0]   m_exp_addr = '0;
   bit            m_busy     = 0;
   bit            m_squash   = 0;
   bit            m_exp_fetch = 0;
   bit            prev_do    = 0;

   int            mmu_cnt    = 0;
   bit            mmu_stray  = 0;
   bit            redir_on_done = 0;
   logic [63:0]   redir_on_done_tgt = '0;

   task automatic cycle(input bit rst, input bit rv, input logic [63:0] tgt, input bit rdy);
      bundle_entry_t e;
      int            cnt0;
      doneFetch = 1'b0;
      fetchData = {$urandom, $urandom};
      if (mmu_cnt > 0) begin
         mmu_cnt--;
         if (mmu_cnt == 0) doneFetch = 1'b1;
      end
      if (mmu_stray) begin
         doneFetch = 1'b1;
         mmu_stray = 0;
      end
      if (redir_on_done && doneFetch && !rst) begin
         rv            = 1;
         tgt           = redir_on_done_tgt;
         redir_on_done = 0;
      end
      reset          = rst;
      redirectValid  = rv;
      redirectTarget = tgt;
      bundleReady    = rdy;

      cnt0        = mq.size();
      m_exp_fetch = 0;
      if (rst) begin
         m_pc     = RPC;
         m_busy   = 0;
         m_squash = 0;
         mq.delete();
      end else if (rv) begin
         m_pc = tgt & AMASK;
         mq.delete();
         if (m_busy) begin
            if (doneFetch) begin
               m_busy   = 0;
               m_squash = 0;
            end else begin
               m_squash = 1;
            end
         end
      end else begin
         if (cnt0 > 0 && rdy) void'(mq.pop_front());
         if (m_busy) begin
            if (doneFetch) begin
               if (!m_squash) begin
                  e.bundle = fetchData;
                  e.pc     = m_inflight;
                  mq.push_back(e);
                  m_pc = m_pc + STEP;
               end else begin
                  m_squash = 0;
               end
               m_busy = 0;
            end
         end else if (cnt0 < DEPTH) begin
            m_exp_fetch = 1;
            m_exp_addr  = m_pc;
            m_inflight  = m_pc;
            m_busy      = 1;
         end
      end

      @(posedge clk);
      #1;
      if (rst) begin
         check_eq("reset_doFetch", doFetch, 0);
         check_eq("reset_fetchAddress", fetchAddress, RPC);
         check_eq("reset_bundleValid", bundleValid, 0);
         check_eq("reset_bundleOut", bundleOut, 0);
         check_eq("reset_bundlePc", bundlePc, 0);
      end
      check_eq("doFetch", doFetch, m_exp_fetch);
      if (m_exp_fetch) check_eq("fetchAddress", fetchAddress, m_exp_addr);
      check_eq("no_back_to_back", prev_do & doFetch, 0);
      prev_do = doFetch;
      check_eq("bundleValid", bundleValid, mq.size() != 0);
      if (mq.size() != 0) begin
         check_eq("bundleOut", bundleOut, mq[0].bundle);
         check_eq("bundlePc", bundlePc, mq[0].pc);
      end
      if (doFetch) mmu_cnt = 3;
   endtask

   task automatic wait_fetch(input string tag, input logic [63:0] exp_addr);
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cycle(0, 0, '0, 1);
         if (doFetch) seen = 1;
      end
      check_eq({tag, "_seen"}, seen, 1);
      if (seen) check_eq(tag, fetchAddress, exp_addr);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cycle(1, 0, '0, 1);
   endtask

   initial begin
      int  nreq;
      bit  found;

      // Basic streaming with a ready consumer
      do_reset(2);
      wait_fetch("first_fetch", 64'h1000);
      wait_fetch("second_fetch", 64'h1008);
      wait_fetch("third_fetch", 64'h1010);
      for (int i = 0; i < 20; i++) cycle(0, 0, '0, 1);

      // Back-pressure: FIFO fills after four requests
      do_reset(1);
      nreq = 0;
      for (int i = 0; i < 60; i++) begin
         cycle(0, 0, '0, 0);
         if (doFetch) nreq++;
      end
      check_eq("stall_request_count", nreq, 4);
      wait_fetch("resume_fetch", 64'h1020);
      for (int i = 0; i < 20; i++) cycle(0, 0, '0, 1);

      // Redirect while a request is outstanding
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (m_busy && mmu_cnt > 1) begin
            cycle(0, 1, 64'h2004, 1);
            found = 1;
            check_eq("redirect_flush_valid", bundleValid, 0);
         end else begin
            cycle(0, 0, '0, 1);
         end
      end
      check_eq("redirect_wait_found", found, 1);
      wait_fetch("redirect_fetch", 64'h2000);

      // Redirect coinciding with the response
      redir_on_done     = 1;
      redir_on_done_tgt = 64'h3000;
      for (int i = 0; i < 30 && redir_on_done; i++) cycle(0, 0, '0, 1);
      check_eq("redirect_on_done_fired", redir_on_done, 0);
      check_eq("redirect_on_done_empty", bundleValid, 0);
      wait_fetch("redirect_on_done_fetch", 64'h3000);

      // Redirect coinciding with a dequeue
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         cycle(0, 0, '0, 0);
         found = bundleValid;
      end
      check_eq("dequeue_valid_found", found, 1);
      cycle(0, 1, 64'h4000, 1);
      check_eq("redirect_dequeue_valid", bundleValid, 0);

      // Address wrap at the top of the space
      cycle(0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1);
      wait_fetch("wrap_fetch_top", 64'hFFFF_FFFF_FFFF_FFF8);
      wait_fetch("wrap_fetch_zero", 64'h0);

      // Reset in WAIT, then a stray response in ISSUE
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         cycle(0, 0, '0, 1);
         found = m_busy && mmu_cnt > 1;
      end
      check_eq("reset_wait_found", found, 1);
      do_reset(4);
      mmu_stray = 1;
      wait_fetch("post_reset_fetch", 64'h1000);
      check_eq("stray_ignored", bundleValid, 0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         bit          rv;
         bit          rdy;
         bit          rst;
         logic [63:0] tgt;
         rst = ($urandom_range(0, 199) == 0);
         rv  = ($urandom_range(0, 99) < 4);
         rdy = ($urandom_range(0, 99) < 60);
         if ($urandom_range(0, 1) == 0) tgt = {$urandom, $urandom};
         else tgt = 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(0, 255));
         cycle(rst, rv, tgt, rdy);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
